// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite encodings and helpers
//
// Purpose : HTRANS/HBURST encodings, master index width and small
//           transfer-classification helpers used by the arbiter/mux.
// Ports   : none (package)

package ahb_pkg;

   // Largest supported master count; the index width covers it.
   localparam int MAX_M = 8;
   localparam int IDX_W = $clog2(MAX_M);

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;

   // A master requests the bus when it presents NONSEQ or SEQ.
   function automatic logic is_active(input logic [1:0] htrans);
      return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
   endfunction

   // The owner may be replaced only between transfers that are not part of
   // an ongoing burst: SEQ, or NONSEQ opening a burst, keep the grant.
   function automatic logic is_switchable(input logic [1:0] htrans,
                                          input logic [2:0] hburst);
      logic sw;
      sw = 1'b1;
      if (htrans == HTRANS_SEQ)
         sw = 1'b0;
      else if ((htrans == HTRANS_NONSEQ) && (hburst != HBURST_SINGLE))
         sw = 1'b0;
      return sw;
   endfunction

endpackage

// File: rtl/ahb_rr_arbiter.sv
// rtl/ahb_rr_arbiter.sv - combinational fixed/round-robin winner select
//
// Purpose : picks one requester. Fixed mode: lowest index wins.
//           Round-robin mode: the search starts at ptr and wraps, so the
//           master just below ptr ranks last.
// Ports   : req       in  NUM_M  request vector
//           ptr       in  IDX_W  round-robin start index (ignored in fixed mode)
//           rr_mode   in  1      1 = round-robin, 0 = fixed priority
//           grant_oh  out NUM_M  one-hot winner, all zero when no request
//           grant_idx out IDX_W  winner index, 0 when no request

module ahb_rr_arbiter
   import ahb_pkg::*;
#(
   parameter int NUM_M = 2
) (
   input  logic [NUM_M-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   input  logic             rr_mode,
   output logic [NUM_M-1:0] grant_oh,
   output logic [IDX_W-1:0] grant_idx
);

   int   start;
   int   rank;
   int   best;
   int   win;
   logic found;

   // Each requester gets a rank = distance from the start index; the
   // smallest rank wins. This avoids indexing by a computed position.
   always_comb begin
      start = rr_mode ? int'(ptr) : 0;
      rank  = 0;
      best  = NUM_M;
      win   = 0;
      found = 1'b0;
      for (int i = 0; i < NUM_M; i++) begin
         rank = i - start;
         if (rank < 0)
            rank = rank + NUM_M;
         if (req[i] && (rank < best)) begin
            best  = rank;
            win   = i;
            found = 1'b1;
         end
      end
      grant_oh  = found ? (NUM_M'(1) << win) : '0;
      grant_idx = IDX_W'(win);
   end

endmodule

// File: rtl/ahblite_master_arbmux.sv
// rtl/ahblite_master_arbmux.sv - multi-master AHB-Lite arbiter and bus mux
//
// Purpose : shares one AHB-Lite slave port between NUM_M masters (2..8).
//           Tracks the address-phase owner (aown) and the data-phase owner
//           (down, valid when dval). Address/control follow aown, write data
//           follows down, read data is broadcast.
// Params  : NUM_M (2..8), ARB_MODE (0 fixed, 1 round-robin), ADDR_W, DATA_W
// Ports   : HCLK, HRESET                       clock, sync active-high reset
//           HADDR_M/HTRANS_M/HWRITE_M/HSIZE_M/
//           HBURST_M/HPROT_M/HWDATA_M         per-master request side, slice i
//           HRDATA_M/HREADY_M/HRESP_M         per-master response side
//           HADDR/HTRANS/HWRITE/HSIZE/HBURST/
//           HPROT/HWDATA                       slave-side bus
//           HRDATA/HREADY/HRESP                slave response
//           HMASTER                            current address-phase owner

module ahblite_master_arbmux
   import ahb_pkg::*;
#(
   parameter int NUM_M    = 2,
   parameter int ARB_MODE = 1,
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32
) (
   input  logic                      HCLK,
   input  logic                      HRESET,
   input  logic [NUM_M*ADDR_W-1:0]   HADDR_M,
   input  logic [NUM_M*2-1:0]        HTRANS_M,
   input  logic [NUM_M-1:0]          HWRITE_M,
   input  logic [NUM_M*3-1:0]        HSIZE_M,
   input  logic [NUM_M*3-1:0]        HBURST_M,
   input  logic [NUM_M*4-1:0]        HPROT_M,
   input  logic [NUM_M*DATA_W-1:0]   HWDATA_M,
   output logic [NUM_M*DATA_W-1:0]   HRDATA_M,
   output logic [NUM_M-1:0]          HREADY_M,
   output logic [NUM_M-1:0]          HRESP_M,
   output logic [ADDR_W-1:0]         HADDR,
   output logic [1:0]                HTRANS,
   output logic                      HWRITE,
   output logic [2:0]                HSIZE,
   output logic [2:0]                HBURST,
   output logic [3:0]                HPROT,
   output logic [DATA_W-1:0]         HWDATA,
   input  logic [DATA_W-1:0]         HRDATA,
   input  logic                      HREADY,
   input  logic                      HRESP,
   output logic [2:0]                HMASTER
);

   localparam logic RR_MODE = (ARB_MODE != 0);

   logic [IDX_W-1:0] aown;
   logic [IDX_W-1:0] down;
   logic             dval;

   logic [NUM_M-1:0] req;
   logic [NUM_M-1:0] own_oh;
   logic [NUM_M-1:0] grant_oh;
   logic [IDX_W-1:0] grant_idx;
   logic [IDX_W-1:0] rr_ptr;
   logic [1:0]       own_trans;
   logic [2:0]       own_burst;
   logic             take_new;

   always_comb begin
      req = '0;
      for (int i = 0; i < NUM_M; i++)
         req[i] = is_active(HTRANS_M[2*i +: 2]);
   end

   assign own_trans = HTRANS_M[int'(aown)*2 +: 2];
   assign own_burst = HBURST_M[int'(aown)*3 +: 3];
   assign own_oh    = NUM_M'(1) << aown;

   // Round-robin search begins just after the current owner, so the owner
   // itself is considered last.
   assign rr_ptr = (int'(aown) == NUM_M - 1) ? '0 : aown + IDX_W'(1);

   ahb_rr_arbiter #(
      .NUM_M (NUM_M)
   ) u_arb (
      .req       (req),
      .ptr       (rr_ptr),
      .rr_mode   (RR_MODE),
      .grant_oh  (grant_oh),
      .grant_idx (grant_idx)
   );

   // In fixed mode a requesting owner with the lowest index can win against
   // other requesters; only a winner different from the owner moves aown.
   assign take_new = is_switchable(own_trans, own_burst) && |(grant_oh & ~own_oh);

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         aown <= '0;
         down <= '0;
         dval <= 1'b0;
      end else if (HREADY) begin
         down <= aown;
         dval <= is_active(own_trans);
         if (take_new)
            aown <= grant_idx;
      end
   end

   // Slave-side address/control follow the address owner.
   assign HADDR   = HADDR_M[int'(aown)*ADDR_W +: ADDR_W];
   assign HTRANS  = own_trans;
   assign HWRITE  = HWRITE_M[aown];
   assign HSIZE   = HSIZE_M[int'(aown)*3 +: 3];
   assign HBURST  = own_burst;
   assign HPROT   = HPROT_M[int'(aown)*4 +: 4];
   assign HWDATA  = HWDATA_M[int'(down)*DATA_W +: DATA_W];
   assign HMASTER = 3'(aown);

   assign HRDATA_M = {NUM_M{HRDATA}};

   // Masters that neither own the address phase nor the live data phase are
   // stalled while they request, which keeps their address phase pending.
   always_comb begin
      HREADY_M = '0;
      HRESP_M  = '0;
      for (int i = 0; i < NUM_M; i++) begin
         if ((int'(aown) == i) || (dval && (int'(down) == i)))
            HREADY_M[i] = HREADY;
         else
            HREADY_M[i] = ~req[i];
         if (dval && (int'(down) == i))
            HRESP_M[i] = HRESP;
      end
   end

endmodule
